// File: rtl/aes_pkg.sv
// Shared AES constants: round count, word geometry, FSM state type,
// the forward S-box and the round constant table.
package aes_pkg;

    localparam int NR   = 10;
    localparam int BYTE = 8;
    localparam int WORD = 32;

    typedef enum logic {
        IDLE,
        EMIT
    } ks_state_t;

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Forward S-box lookup, shared with the SubBytes stage.
    function automatic logic [BYTE-1:0] sbox(input logic [BYTE-1:0] b);
        return SBOX[b];
    endfunction

    // Round constant for rounds 1..10; anything else yields zero so an
    // out-of-range index never produces X.
    function automatic logic [BYTE-1:0] rcon(input logic [3:0] round);
        logic [BYTE-1:0] rc;
        case (round)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word, purely combinational.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [WORD-1:0] word_in,
    output logic [WORD-1:0] word_out
);

    // Each byte lane goes through its own S-box lookup.
    always_comb begin
        word_out = '0;
        for (int i = 0; i < WORD / BYTE; i++) begin
            word_out[i*BYTE +: BYTE] = sbox(word_in[i*BYTE +: BYTE]);
        end
    end

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion: one round key per handshake, computed on
// the fly from the previous round key held in the output register.
module aes_key_schedule
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key,
    input  logic         rk_ready,
    output logic         rk_valid,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         busy,
    output logic         done
);

    localparam logic [3:0] LAST_IDX = 4'(NR);

    ks_state_t       state;
    logic [WORD-1:0] w0, w1, w2, w3;
    logic [WORD-1:0] rot_word, sub_word, temp;
    logic [WORD-1:0] n0, n1, n2, n3;

    assign w0 = round_key[127:96];
    assign w1 = round_key[95:64];
    assign w2 = round_key[63:32];
    assign w3 = round_key[31:0];

    assign rot_word = {w3[23:0], w3[31:24]};

    aes_sub_word u_sub_word (
        .word_in  (rot_word),
        .word_out (sub_word)
    );

    assign temp = sub_word ^ {rcon(round_idx + 4'd1), 24'h000000};
    assign n0   = w0 ^ temp;
    assign n1   = w1 ^ n0;
    assign n2   = w2 ^ n1;
    assign n3   = w3 ^ n2;

    assign busy = (state != IDLE);

    // FSM plus round-key/index registers; the next key replaces the current one on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rk_valid  <= 1'b0;
            round_key <= '0;
            round_idx <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        round_key <= key;
                        round_idx <= 4'd0;
                        rk_valid  <= 1'b1;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (rk_ready) begin
                        if (round_idx == LAST_IDX) begin
                            rk_valid <= 1'b0;
                            done     <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            round_key <= {n0, n1, n2, n3};
                            round_idx <= round_idx + 4'd1;
                        end
                    end
                end
                default: begin
                    rk_valid <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
